add_seq_ctrl: RTL and testbench
===============================

// Module: add_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer that performs a CHUNKS*WIDTH-bit addition using one shared WIDTH-bit ripple adder.
//  Each cycle it feeds the adder one WIDTH-bit slice (LSB slice first) and registers the inter-slice carry.
//  It assembles the full sum and returns it over a valid/ready handshake.
//  Used where a wide adder is too costly and a few cycles of latency are acceptable.
// PARAMETERS
//  WIDTH   4  bits per slice; width of the shared ripple adder (>=1)
//  CHUNKS  4  number of slices per operation (>=1); total operand width TW = WIDTH*CHUNKS
// PORTS
//  clk        in   1    rising-edge clock
//  rst_n      in   1    asynchronous active-low reset
//  in_valid   in   1    operands a/b/cin valid
//  in_ready   out  1    block can accept an operation (high only in IDLE)
//  a          in   TW   operand A, sampled on the accept edge
//  b          in   TW   operand B, sampled on the accept edge
//  cin        in   1    carry into slice 0, sampled on the accept edge
//  out_valid  out  1    sum/cout valid
//  out_ready  in   1    consumer accepts the result
//  sum        out  TW   registered result
//  cout       out  1    carry out of the top slice
//  busy       out  1    high in RUN or DONE
// BEHAVIOUR
//  - Reset (rst_n low, async): state=IDLE, cnt=0, carry=0, sum=0, cout=0, out_valid=0, busy=0.
//    in_ready is decoded from state, so it reads 1 during reset.
//  - FSM states: IDLE, RUN, DONE.
//  - IDLE: in_ready=1.
//    On in_valid=1: latch a, b, cin into op regs; carry<=cin; cnt<=0; go to RUN.
//  - RUN: adder inputs are a_r[cnt*WIDTH +: WIDTH], b_r[cnt*WIDTH +: WIDTH] and carry.
//    Each edge: write the slice sum into sum_r[cnt*WIDTH +: WIDTH], carry<=adder carry-out, cnt<=cnt+1.
//    When cnt==CHUNKS-1: cout<=adder carry-out; out_valid<=1; go to DONE.
//  - DONE: out_valid=1. sum and cout stay stable until the handshake.
//    On out_ready=1: out_valid<=0; go to IDLE.
//    Outputs sum and cout keep their last value after the handshake.
//  - Latency: out_valid rises exactly CHUNKS cycles after the accept edge.
//    Minimum issue interval is CHUNKS+2 cycles: in_ready is low during RUN and DONE.
//    There is no same-cycle accept in DONE.
//  - in_valid and operand changes outside IDLE are ignored; operands are copied on acceptance.
//  - out_ready outside DONE has no effect.
//  - Arithmetic: result is modulo 2^TW; {cout,sum} == a+b+cin exactly. No overflow flag.
//  - cnt is $clog2(CHUNKS) bits wide, minimum 1 bit. For CHUNKS==1, RUN lasts one cycle.
//  - Reset asserted in RUN or DONE: aborts immediately. The partial result is discarded and all outputs return to reset values.
//  - Only one adder instance exists. No combinational path from a, b or in_valid to any output.
// TESTING
//  1. WIDTH=4, CHUNKS=4: a=16'hFFFF, b=16'h0001, cin=0 -> 4 cycles after accept: out_valid=1, sum=16'h0000, cout=1 (carry ripples through all slices).
//  2. a=16'h1234, b=16'h4321, cin=1 -> sum=16'h5556, cout=0. in_ready stays low from the accept edge until the return to IDLE.
//  3. Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid and a/b.
//     -> sum and cout stay stable, in_ready=0, no new accept. out_ready=1 -> IDLE next edge.
//  4. Assert rst_n=0 on the 2nd RUN cycle -> out_valid, sum, cout, busy all 0 at once; state IDLE.
//     After release, a fresh a=16'h00FF, b=16'h0001 -> sum=16'h0100.
//  5. in_valid and out_ready tied high, 100 random operand pairs -> one accept every 6 cycles.
//     Every result matches the a+b+cin reference model.
//  6. Parameter sweep WIDTH=1/CHUNKS=8 and WIDTH=8/CHUNKS=1 with random operands -> correct {cout,sum}.
//     Latency is 8 cycles and 1 cycle respectively.

Source files
------------

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: CHUNKS*WIDTH-bit adder built from one shared WIDTH-bit adder,
// one slice per cycle (LSB first), with valid/ready handshakes on both sides.
module add_seq_ctrl #(
    parameter int WIDTH  = 4,
    parameter int CHUNKS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH*CHUNKS-1:0]   a,
    input  logic [WIDTH*CHUNKS-1:0]   b,
    input  logic                      cin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH*CHUNKS-1:0]   sum,
    output logic                      cout,
    output logic                      busy
);
    localparam int CW = CHUNKS > 1 ? $clog2(CHUNKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_d;
    logic [CW-1:0] cnt;
    logic carry, cout_r, co, last;
    logic [CHUNKS-1:0][WIDTH-1:0] a_r, b_r, sum_r;
    logic [WIDTH-1:0] s;
    // The single shared slice adder, fed by the slice selected with cnt
    assign {co, s} = {1'b0, a_r[cnt]} + {1'b0, b_r[cnt]} + {{WIDTH{1'b0}}, carry};
    assign last = cnt == LAST;
    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    assign busy = state != IDLE;
    assign sum = sum_r;
    assign cout = cout_r;
    always_comb begin
        state_d = state;
        state_d = (state == IDLE && in_valid) ? RUN :
                  (state == RUN && last) ? DONE :
                  (state == DONE && out_ready) ? IDLE : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            sum_r  <= '0;
        end else begin
            state <= state_d;
            if (state == IDLE && in_valid) begin
                a_r   <= a;
                b_r   <= b;
                carry <= cin;
                cnt   <= '0;
            end
            if (state == RUN) begin
                sum_r[cnt] <= s;
                carry      <= co;
                cnt        <= last ? '0 : cnt + 1'b1;
                if (last) cout_r <= co;
            end
        end
    end
endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb_add_seq_ctrl: directed checks of the slice-sequenced adder, including a
// WIDTH=1/CHUNKS=8 and a WIDTH=8/CHUNKS=1 instance for the parameter sweep.
module tb_add_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic iv, ir, ov, ordy, cin, cout, busy;
    logic [15:0] a, b, sum;
    logic iv8, ordy8, cin8;
    logic [7:0] a8, b8;
    logic ir1, ov1, cout1, busy1, ir2, ov2, cout2, busy2;
    logic [7:0] sum1, sum2;
    int total = 0, passed = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    add_seq_ctrl #(.WIDTH(4), .CHUNKS(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .a(a), .b(b), .cin(cin),
        .out_valid(ov), .out_ready(ordy), .sum(sum), .cout(cout), .busy(busy));
    add_seq_ctrl #(.WIDTH(1), .CHUNKS(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir1), .a(a8), .b(b8), .cin(cin8),
        .out_valid(ov1), .out_ready(ordy8), .sum(sum1), .cout(cout1), .busy(busy1));
    add_seq_ctrl #(.WIDTH(8), .CHUNKS(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir2), .a(a8), .b(b8), .cin(cin8),
        .out_valid(ov2), .out_ready(ordy8), .sum(sum2), .cout(cout2), .busy(busy2));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // Called at a negedge in IDLE; returns at a negedge back in IDLE.
    task automatic op16(input logic [15:0] x, input logic [15:0] y, input logic c,
                        input logic [15:0] es, input logic ec, input string tag);
        int n;
        logic low;
        a = x; b = y; cin = c; iv = 1'b1;
        @(negedge clk);
        iv = 1'b0; a = ~x; b = ~y; cin = ~c;
        check({tag, "_rdy_low"}, 64'(ir), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(1));
        n = 0; low = 1'b1;
        while (!ov && n < 20) begin
            @(negedge clk);
            n++;
            low &= ~ir;
        end
        check({tag, "_latency"}, 64'(n), 64'(4));
        check({tag, "_rdy_stays_low"}, 64'(low), 64'(1));
        check({tag, "_sum"}, 64'(sum), 64'(es));
        check({tag, "_cout"}, 64'(cout), 64'(ec));
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
        check({tag, "_idle_rdy"}, 64'(ir), 64'(1));
        check({tag, "_idle_ov"}, 64'(ov), 64'(0));
    endtask

    initial begin
        int n, acc, l1, l2;
        logic ok;
        logic [15:0] x, y;
        logic c;
        logic [16:0] r17;
        logic [8:0] r9;
        rst_n = 1'b0; iv = 1'b0; ordy = 1'b0; a = '0; b = '0; cin = 1'b0;
        iv8 = 1'b0; ordy8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        #12;
        check("rst_in_ready", 64'(ir), 64'(1));
        check("rst_out_valid", 64'(ov), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_sum_cout", 64'({cout, sum}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        op16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "t1");
        op16(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, "t2");

        // Backpressure in DONE with noise on the input side
        a = 16'hABCD; b = 16'h8765; cin = 1'b0; iv = 1'b1;
        @(negedge clk);
        n = 0;
        while (!ov && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t3_done", 64'(ov), 64'(1));
        ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            iv = k[0]; a = 16'($urandom); b = 16'($urandom);
            @(negedge clk);
            ok &= (sum === 16'h3332) && (cout === 1'b1) && (ir === 1'b0) && (ov === 1'b1);
        end
        check("t3_stable", 64'(ok), 64'(1));
        iv = 1'b0; ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
        check("t3_idle_rdy", 64'(ir), 64'(1));
        check("t3_sum_kept", 64'({cout, sum}), 64'(17'h13332));

        // Abort by reset in the second RUN cycle
        a = 16'h1111; b = 16'h2222; cin = 1'b0; iv = 1'b1;
        @(negedge clk);
        iv = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t4_ov", 64'(ov), 64'(0));
        check("t4_sum_cout", 64'({cout, sum}), 64'(0));
        check("t4_busy", 64'(busy), 64'(0));
        check("t4_rdy", 64'(ir), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        op16(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, "t4_after");

        // Streaming with both handshakes tied high
        iv = 1'b1; ordy = 1'b1; acc = 0;
        for (int k = 0; k < 100; k++) begin
            n = 0;
            while (!ir && n < 20) begin
                @(negedge clk);
                n++;
            end
            x = 16'($urandom); y = 16'($urandom); c = 1'($urandom_range(0, 1));
            a = x; b = y; cin = c;
            r17 = {1'b0, x} + {1'b0, y} + {16'b0, c};
            if (k > 0) check("t5_interval", 64'(cyc - acc), 64'(6));
            acc = cyc;
            @(negedge clk);
            a = 16'($urandom); b = 16'($urandom);
            n = 0;
            while (!ov && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("t5_result", 64'({cout, sum}), 64'(r17));
        end
        @(negedge clk);
        iv = 1'b0; ordy = 1'b0;
        @(negedge clk);

        // Parameter sweep: both 8-bit instances run the same operands in parallel
        for (int k = 0; k < 6; k++) begin
            a8 = (k == 0) ? 8'hFF : 8'($urandom);
            b8 = (k == 0) ? 8'h00 : 8'($urandom);
            cin8 = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            r9 = {1'b0, a8} + {1'b0, b8} + {8'b0, cin8};
            iv8 = 1'b1;
            @(negedge clk);
            iv8 = 1'b0;
            l1 = 0; l2 = 0;
            for (int t = 1; t <= 12; t++) begin
                @(negedge clk);
                if (ov1 && l1 == 0) l1 = t;
                if (ov2 && l2 == 0) l2 = t;
            end
            check("t6_lat_w1c8", 64'(l1), 64'(8));
            check("t6_lat_w8c1", 64'(l2), 64'(1));
            check("t6_res_w1c8", 64'({cout1, sum1}), 64'(r9));
            check("t6_res_w8c1", 64'({cout2, sum2}), 64'(r9));
            ordy8 = 1'b1;
            @(negedge clk);
            ordy8 = 1'b0;
            check("t6_idle", 64'({ir1, ir2}), 64'(2'b11));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
